// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, material weights, board geometry, register map and evaluator states
package chess_pkg;
    localparam int NUM_SQUARES = 64;
    localparam int BOARD_BYTES = NUM_SQUARES * 4;
    typedef enum logic [7:0] {
        EMPTY  = 8'd0,
        PAWN   = 8'd1,
        KNIGHT = 8'd2,
        BISHOP = 8'd3,
        ROOK   = 8'd4,
        QUEEN  = 8'd5,
        KING   = 8'd6
    } piece_t;
    localparam logic signed [31:0] W_PAWN   = 32'sd100;
    localparam logic signed [31:0] W_KNIGHT = 32'sd320;
    localparam logic signed [31:0] W_BISHOP = 32'sd330;
    localparam logic signed [31:0] W_ROOK   = 32'sd500;
    localparam logic signed [31:0] W_QUEEN  = 32'sd900;
    localparam logic signed [31:0] W_KING   = 32'sd20000;
    localparam logic [31:0] BEST_INIT = 32'h8000_0000;
    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_SRC   = 4'd1;
    localparam logic [3:0] REG_NUM   = 4'd2;
    localparam logic [3:0] REG_SCORE = 4'd3;
    localparam logic [3:0] REG_BEST  = 4'd4;
    localparam logic [3:0] REG_IDX   = 4'd5;
    typedef enum logic [3:0] {
        IDLE, CLEAR, CHECK, RD_SQ, WT_SQ, ACC, WR_SCORE, NEXT, DONE
    } state_t;
endpackage

// File: rtl/board_eval_if.sv
// board_eval_if: Avalon-MM bus bundle, used for both the CPU slave port and the SDRAM master port
interface board_eval_if #(
    parameter int AW = 32
);
    logic          waitrequest;
    logic [AW-1:0] address;
    logic          read;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic          write;
    logic [31:0]   writedata;
    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, read, write, writedata
    );
    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/piece_weight.sv
// piece_weight: signed piece code to signed material contribution (white positive, black negative)
module piece_weight
    import chess_pkg::*;
(
    input  logic signed [7:0]  piece,
    output logic signed [31:0] contribution
);
    logic [7:0] mag;
    logic signed [31:0] w;
    // -128 folds to 0x80, which is not a piece and therefore weighs nothing
    assign mag = piece[7] ? 8'(-piece) : piece;
    assign w = mag == PAWN   ? W_PAWN   :
               mag == KNIGHT ? W_KNIGHT :
               mag == BISHOP ? W_BISHOP :
               mag == ROOK   ? W_ROOK   :
               mag == QUEEN  ? W_QUEEN  :
               mag == KING   ? W_KING   : 32'sd0;
    assign contribution = piece[7] ? -w : w;
endmodule

// File: rtl/board_eval.sv
// board_eval: scores successor boards read from SDRAM, writes each score back and tracks the best
module board_eval
    import chess_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    board_eval_if.slave  slave,
    board_eval_if.master master
);
    state_t state, state_nx;
    logic [31:0] src_base, score_base, best_index, boards_done;
    logic signed [31:0] best_score, acc, contrib;
    logic [CNT_W-1:0] num_boards, b;
    logic [5:0] sq;
    logic [7:0] piece_q;
    logic busy, start, ctrl_rd, last_sq;

    assign busy    = !(state == IDLE || state == DONE);
    assign start   = slave.write && slave.address == REG_CTRL;
    assign ctrl_rd = slave.read && slave.address == REG_CTRL;
    assign last_sq = sq == 6'(NUM_SQUARES - 1);

    piece_weight u_weight (
        .piece        (piece_q),
        .contribution (contrib)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? CLEAR : IDLE;
            CLEAR:    state_nx = CHECK;
            CHECK:    state_nx = b == num_boards ? DONE : RD_SQ;
            RD_SQ:    state_nx = master.waitrequest ? RD_SQ : WT_SQ;
            WT_SQ:    state_nx = master.readdatavalid ? ACC : WT_SQ;
            ACC:      state_nx = last_sq ? WR_SCORE : RD_SQ;
            WR_SCORE: state_nx = master.waitrequest ? WR_SCORE : NEXT;
            NEXT:     state_nx = CHECK;
            DONE:     state_nx = start ? CLEAR : ctrl_rd ? IDLE : DONE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_base    <= '0;
            score_base  <= '0;
            num_boards  <= '0;
            best_score  <= BEST_INIT;
            best_index  <= '1;
            boards_done <= '0;
            acc         <= '0;
            b           <= '0;
            sq          <= '0;
            piece_q     <= '0;
        end else begin
            if (!busy && slave.write) begin
                if (slave.address == REG_SRC) src_base <= slave.writedata;
                if (slave.address == REG_NUM) num_boards <= slave.writedata[CNT_W-1:0];
                if (slave.address == REG_SCORE) score_base <= slave.writedata;
            end
            case (state)
                CLEAR: begin
                    best_score  <= BEST_INIT;
                    best_index  <= '1;
                    boards_done <= '0;
                    acc         <= '0;
                    b           <= '0;
                    sq          <= '0;
                end
                WT_SQ: if (master.readdatavalid) piece_q <= master.readdata[7:0];
                ACC: begin
                    acc <= acc + contrib;
                    if (!last_sq) sq <= sq + 6'd1;
                end
                NEXT: begin
                    // strict compare so ties keep the earliest board
                    if (acc > best_score) begin
                        best_score <= acc;
                        best_index <= 32'(b);
                    end
                    b           <= b + 1'b1;
                    boards_done <= boards_done + 32'd1;
                    sq          <= '0;
                    acc         <= '0;
                end
                default: ;
            endcase
        end
    end

    assign master.read      = state == RD_SQ;
    assign master.write     = state == WR_SCORE;
    assign master.address   = state == RD_SQ ? src_base + 32'(b) * 32'(BOARD_BYTES) + 32'({sq, 2'b00}) :
                              state == WR_SCORE ? score_base + 32'({b, 2'b00}) : '1;
    assign master.writedata = state == WR_SCORE ? acc : '1;

    assign slave.waitrequest   = ctrl_rd && busy;
    assign slave.readdata      = !slave.read ? '0 :
                                 slave.address == REG_CTRL ? boards_done :
                                 slave.address == REG_BEST ? best_score :
                                 slave.address == REG_IDX  ? best_index : '0;
    assign slave.readdatavalid = slave.read && !slave.waitrequest;
endmodule

// File: tb/tb_board_eval.sv
// tb_board_eval: directed and randomized checks of board_eval against a material-count model
module tb_board_eval;
    import chess_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    board_eval_if #(.AW(4)) cpu ();
    board_eval_if mem ();

    board_eval dut (
        .clk    (clk),
        .rst    (rst),
        .slave  (cpu),
        .master (mem)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;
    logic [31:0] sdram [int unsigned];
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    int nreads, nwrites, strobes;
    bit stall_en = 0, lat_en = 0;
    bit pend = 0;
    int dly = 0;
    logic [31:0] pdata;
    bit prev_stalled = 0;
    logic [31:0] prev_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SDRAM slave: random stalls, 1-5 cycle read latency, score-write capture
    initial begin
        mem.waitrequest = 1'b0;
        mem.readdatavalid = 1'b0;
        mem.readdata = '0;
        forever begin
            @(negedge clk);
            mem.readdatavalid = 1'b0;
            mem.readdata = $urandom;
            if (pend) begin
                if (dly <= 1) begin
                    mem.readdatavalid = 1'b1;
                    mem.readdata = pdata;
                    pend = 0;
                end else dly--;
            end
            mem.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (mem.read || mem.write) strobes++;
            if (rst) prev_stalled = 0;
            else begin
                if (prev_stalled) begin
                    check("rd_held", 32'(mem.read), 32'd1);
                    check("rd_addr_held", mem.address, prev_addr);
                end
                prev_stalled = 0;
                if (mem.read) begin
                    if (mem.waitrequest) begin
                        prev_stalled = 1;
                        prev_addr = mem.address;
                    end else begin
                        check("one_outstanding", 32'(pend), 32'd0);
                        pend = 1;
                        dly = lat_en ? int'($urandom_range(1, 5)) : 1;
                        pdata = sdram.exists(mem.address) ? sdram[mem.address] : 32'h0;
                        nreads++;
                    end
                end
                if (mem.write && !mem.waitrequest) begin
                    wq_addr.push_back(mem.address);
                    wq_data.push_back(mem.writedata);
                    nwrites++;
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu.address = a;
        cpu.writedata = d;
        cpu.write = 1'b1;
        @(negedge clk);
        cpu.write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, input int budget, output logic [31:0] d, output bit stalled);
        int n;
        n = 0;
        stalled = 0;
        @(negedge clk);
        cpu.address = a;
        cpu.read = 1'b1;
        #1;
        while (cpu.waitrequest && n < budget) begin
            stalled = 1;
            n++;
            @(negedge clk);
            #1;
        end
        check("cpu_wait_bound", 32'(cpu.waitrequest), 32'd0);
        d = cpu.readdata;
        @(negedge clk);
        cpu.read = 1'b0;
    endtask

    function automatic int model_score(input logic [31:0] base);
        int wt [7] = '{0, 100, 320, 330, 500, 900, 20000};
        int s, v, m, x;
        logic [31:0] w;
        s = 0;
        for (int i = 0; i < NUM_SQUARES; i++) begin
            w = sdram.exists(base + 4 * i) ? sdram[base + 4 * i] : 32'h0;
            v = int'($signed(w[7:0]));
            m = v < 0 ? -v : v;
            x = m <= 6 ? wt[m] : 0;
            s += v < 0 ? -x : x;
        end
        return s;
    endfunction

    task automatic clear_boards(input logic [31:0] base, input int n);
        for (int i = 0; i < n * NUM_SQUARES; i++) sdram[base + 4 * i] = {24'($urandom), 8'h00};
    endtask

    task automatic put(input logic [31:0] base, input int bd, input int s, input int code);
        sdram[base + BOARD_BYTES * bd + 4 * s] = {24'($urandom), 8'(code)};
    endtask

    task automatic rand_boards(input logic [31:0] base, input int n);
        int codes [20] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, -1, -2, -3, -4, -5, -6, 9, -128};
        for (int bd = 0; bd < n; bd++)
            for (int s = 0; s < NUM_SQUARES; s++) put(base, bd, s, codes[$urandom_range(0, 19)]);
    endtask

    task automatic setup(input logic [31:0] src, input int n, input logic [31:0] sb);
        wq_addr.delete();
        wq_data.delete();
        nreads = 0;
        nwrites = 0;
        cpu_write(REG_SRC, src);
        cpu_write(REG_NUM, 32'(n));
        cpu_write(REG_SCORE, sb);
        cpu_write(REG_CTRL, 32'h0);
    endtask

    task automatic run(input logic [31:0] src, input int n, input logic [31:0] sb, output logic [31:0] done);
        bit st;
        setup(src, n, sb);
        cpu_read(REG_CTRL, 30000, done, st);
    endtask

    task automatic verify(input string tag, input logic [31:0] src, input int n, input logic [31:0] sb,
                          input logic [31:0] done, output logic [31:0] ob, output logic [31:0] oi);
        logic signed [31:0] best;
        logic [31:0] bi;
        int s;
        bit st;
        best = BEST_INIT;
        bi = '1;
        check({tag, "_done"}, done, 32'(n));
        check({tag, "_nwrites"}, 32'(nwrites), 32'(n));
        check({tag, "_nreads"}, 32'(nreads), 32'(n * NUM_SQUARES));
        for (int bd = 0; bd < n; bd++) begin
            s = model_score(src + BOARD_BYTES * bd);
            if (s > best) begin
                best = s;
                bi = 32'(bd);
            end
            if (bd < wq_data.size()) begin
                check($sformatf("%s_addr%0d", tag, bd), wq_addr[bd], sb + 4 * bd);
                check($sformatf("%s_score%0d", tag, bd), wq_data[bd], 32'(s));
            end
        end
        cpu_read(REG_BEST, 10, ob, st);
        check({tag, "_best"}, ob, best);
        cpu_read(REG_IDX, 10, oi, st);
        check({tag, "_idx"}, oi, bi);
        check({tag, "_idx_nostall"}, 32'(st), 32'd0);
    endtask

    initial begin
        logic [31:0] d, ob, oi;
        bit st;
        int n;
        int exp3 [3] = '{900, -500, 420};
        cpu.address = '0;
        cpu.read = 1'b0;
        cpu.write = 1'b0;
        cpu.writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mread", 32'(mem.read), 32'd0);
        check("rst_mwrite", 32'(mem.write), 32'd0);
        check("rst_maddr", mem.address, 32'hFFFF_FFFF);
        check("rst_mwdata", mem.writedata, 32'hFFFF_FFFF);
        check("rst_swait", 32'(cpu.waitrequest), 32'd0);
        check("rst_srdata", cpu.readdata, 32'd0);
        rst = 1'b0;
        cpu_read(REG_BEST, 10, d, st);
        check("rst_best", d, 32'h8000_0000);
        cpu_read(REG_IDX, 10, d, st);
        check("rst_idx", d, 32'hFFFF_FFFF);
        cpu_read(REG_CTRL, 10, d, st);
        check("rst_done", d, 32'd0);

        clear_boards(32'h1000, 1);
        put(32'h1000, 0, 4, 6);
        put(32'h1000, 0, 60, -6);
        run(32'h1000, 1, 32'h8000, d);
        verify("kings", 32'h1000, 1, 32'h8000, d, ob, oi);
        check("kings_best_lit", ob, 32'd0);
        check("kings_idx_lit", oi, 32'd0);

        clear_boards(32'h2000, 3);
        put(32'h2000, 0, 27, 5);
        put(32'h2000, 1, 0, -4);
        put(32'h2000, 2, 8, 1);
        put(32'h2000, 2, 1, 2);
        run(32'h2000, 3, 32'h9000, d);
        verify("three", 32'h2000, 3, 32'h9000, d, ob, oi);
        for (int i = 0; i < 3; i++)
            if (i < wq_data.size()) check($sformatf("three_lit%0d", i), wq_data[i], 32'(exp3[i]));
        check("three_best_lit", ob, 32'd900);
        check("three_idx_lit", oi, 32'd0);

        clear_boards(32'h3000, 2);
        put(32'h3000, 0, 10, 1);
        put(32'h3000, 1, 50, 1);
        run(32'h3000, 2, 32'h9800, d);
        verify("tie", 32'h3000, 2, 32'h9800, d, ob, oi);
        check("tie_idx_lit", oi, 32'd0);

        strobes = 0;
        setup(32'h3000, 0, 32'h9C00);
        repeat (4) @(negedge clk);
        cpu_read(REG_CTRL, 10, d, st);
        check("zero_done", d, 32'd0);
        check("zero_nostall", 32'(st), 32'd0);
        check("zero_strobes", 32'(strobes), 32'd0);
        cpu_read(REG_IDX, 10, d, st);
        check("zero_idx", d, 32'hFFFF_FFFF);

        stall_en = 1;
        lat_en = 1;
        clear_boards(32'h10000, 4);
        rand_boards(32'h10000, 4);
        run(32'h10000, 4, 32'hA000, d);
        verify("rand", 32'h10000, 4, 32'hA000, d, ob, oi);

        clear_boards(32'h20000, 3);
        rand_boards(32'h20000, 3);
        setup(32'h20000, 3, 32'hB000);
        n = 0;
        while (!(mem.read && mem.address >= 32'h20100) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reach_board1", 32'(mem.read), 32'd1);
        cpu_read(REG_IDX, 10, d, st);
        check("mid_idx", d, 32'd0);
        check("mid_idx_nostall", 32'(st), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_mread", 32'(mem.read), 32'd0);
        check("midrst_mwrite", 32'(mem.write), 32'd0);
        check("midrst_maddr", mem.address, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        cpu_read(REG_BEST, 10, d, st);
        check("midrst_best", d, 32'h8000_0000);
        cpu_read(REG_IDX, 10, d, st);
        check("midrst_idx", d, 32'hFFFF_FFFF);
        cpu_read(REG_CTRL, 10, d, st);
        check("midrst_done", d, 32'd0);
        repeat (10) @(negedge clk);

        clear_boards(32'h30000, 1);
        put(32'h30000, 0, 0, 9);
        put(32'h30000, 0, 1, -7);
        put(32'h30000, 0, 2, 1);
        run(32'h30000, 1, 32'hC000, d);
        verify("odd", 32'h30000, 1, 32'hC000, d, ob, oi);
        check("odd_best_lit", ob, 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
